mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one memory port between an IFU (read-only) and an LSU.
// Latency: 2 cycles from request handshake to resp_valid; one transaction in flight, so at most one per 3 cycles.
// Backpressure: req_ready is high only in IDLE (and never during reset); requesters hold valid/payload until ready.
//
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   if_req_valid/ready, if_addr       IFU read request
//   if_resp_valid, if_resp_data       IFU response (data held until the next IFU response)
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask        LSU read/write request
//   ls_resp_valid, ls_resp_data       LSU response (write response is an acknowledge)
//   mem_valid, mem_wen, mem_addr,
//   mem_wdata, mem_wmask, mem_rdata   memory side; mem_rdata is captured as the ISSUE cycle ends
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  // IFU
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  // LSU
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  // memory
  output logic                mem_valid,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state, state_nxt;

  // Requester encoding: 0 = IFU, 1 = LSU.
  logic                last_grant;
  logic                gnt_ls;       // owner of the transaction in flight
  logic                pick_ls;      // arbitration winner if a handshake happens now
  logic                hs;           // handshake this cycle

  logic [ADDR_W-1:0]   iss_addr;
  logic                iss_wen;
  logic [DATA_W-1:0]   iss_wdata;
  logic [MASK_W-1:0]   iss_wmask;

  // Next state, ready/valid outputs
  always_comb begin
    state_nxt     = state;
    hs            = 1'b0;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_valid     = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    // LSU wins when it is the only one asking, or when both ask and the IFU had the last grant.
    pick_ls       = ls_req_valid & (~if_req_valid | ~last_grant);

    case (state)
      IDLE: begin
        if (!reset && (if_req_valid || ls_req_valid)) begin
          if_req_ready = ~pick_ls;
          ls_req_ready = pick_ls;
          hs           = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid = ~reset;
        state_nxt = RESP;
      end
      RESP: begin
        if_resp_valid = ~reset & ~gnt_ls;
        ls_resp_valid = ~reset & gnt_ls;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory command straight from the issue registers; write enable qualified by valid.
  assign mem_addr  = iss_addr;
  assign mem_wdata = iss_wdata;
  assign mem_wmask = iss_wmask;
  assign mem_wen   = iss_wen & mem_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;          // LSU, so the IFU wins the first contention
      gnt_ls       <= 1'b0;
      iss_addr     <= '0;
      iss_wen      <= 1'b0;
      iss_wdata    <= '0;
      iss_wmask    <= '0;
      if_resp_data <= '0;
      ls_resp_data <= '0;
    end else begin
      state <= state_nxt;

      if (hs) begin
        gnt_ls     <= pick_ls;
        last_grant <= pick_ls;
        iss_addr   <= pick_ls ? ls_addr : if_addr;
        iss_wen    <= pick_ls & ls_wen;   // IFU is read-only
        iss_wdata  <= pick_ls ? ls_wdata : '0;
        iss_wmask  <= pick_ls ? ls_wmask : '0;
      end

      // Read data is captured on the ISSUE->RESP edge for reads and writes alike,
      // and only the owner's response register changes.
      if (state == ISSUE) begin
        if (gnt_ls) ls_resp_data <= mem_rdata;
        else        if_resp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter with expectation queues.
// Latency: expectations are timed in bench cycles (handshake c -> mem_valid c+1 -> resp c+2).
// Backpressure: requester model holds valid/payload stable until its known grant cycle.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req_valid, if_req_ready, if_resp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_resp_data;
  logic          ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_resp_data;
  logic [MW-1:0] ls_wmask;
  logic          mem_valid, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mexp_t;

  typedef struct {
    int            cyc;
    logic          who;      // 0 = IFU, 1 = LSU
    logic          chk_data;
    logic [DW-1:0] data;
  } rexp_t;

  mexp_t mem_q[$];
  rexp_t resp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory contents model: one known instruction word, a fixed pattern elsewhere.
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_5A5A);
  endfunction

  // Memory: data appears once mem_valid is seen and stays until the next access.
  always @(negedge clock) begin
    if (mem_valid) mem_rdata = rd_fn(mem_addr);
  end

  // Output monitor: compares every cycle against the expectation queues.
  always @(negedge clock) begin
    mexp_t me;
    rexp_t re;
    logic  exp_mv, exp_if, exp_ls;
    while (mem_q.size() > 0 && mem_q[0].cyc < cyc) void'(mem_q.pop_front());
    while (resp_q.size() > 0 && resp_q[0].cyc < cyc) void'(resp_q.pop_front());

    exp_mv = (mem_q.size() > 0) && (mem_q[0].cyc == cyc);
    chk("mem_valid", 64'(mem_valid), 64'(exp_mv));
    if (!mem_valid) chk("mem_wen_idle", 64'(mem_wen), 64'd0);
    if (mem_valid && exp_mv) begin
      me = mem_q.pop_front();
      chk("mem_addr", 64'(mem_addr), 64'(me.addr));
      chk("mem_wen", 64'(mem_wen), 64'(me.wen));
      if (me.wen) begin
        chk("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
        chk("mem_wmask", 64'(mem_wmask), 64'(me.wmask));
      end
    end

    chk("ready_exclusive", 64'(if_req_ready & ls_req_ready), 64'd0);

    exp_if = (resp_q.size() > 0) && (resp_q[0].cyc == cyc) && !resp_q[0].who;
    exp_ls = (resp_q.size() > 0) && (resp_q[0].cyc == cyc) && resp_q[0].who;
    chk("if_resp_valid", 64'(if_resp_valid), 64'(exp_if));
    chk("ls_resp_valid", 64'(ls_resp_valid), 64'(exp_ls));
    if (if_resp_valid && exp_if) begin
      re = resp_q.pop_front();
      if (re.chk_data) chk("if_resp_data", 64'(if_resp_data), 64'(re.data));
    end else if (ls_resp_valid && exp_ls) begin
      re = resp_q.pop_front();
      if (re.chk_data) chk("ls_resp_data", 64'(ls_resp_data), 64'(re.data));
    end
  end

  initial begin
    int            t;
    logic [AW-1:0] a;
    logic [DW-1:0] hold [3];

    reset = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    tick();
    tick();

    // Requests raised while still in reset: nobody may be ready.
    if_req_valid = 1'b1; if_addr = 32'h8000_0000;
    ls_req_valid = 1'b1; ls_addr = 32'h8000_2000;
    @(negedge clock);
    chk("rst_if_ready", 64'(if_req_ready), 64'd0);
    chk("rst_ls_ready", 64'(ls_req_ready), 64'd0);
    chk("rst_if_data", 64'(if_resp_data), 64'd0);
    chk("rst_ls_data", 64'(ls_resp_data), 64'd0);

    // Contention straight out of reset: IF, LS, IF, LS, one every 3 cycles.
    tick();
    reset = 1'b0;
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 1) ? 32'h8000_2000 : 32'h8000_0000;
      mem_q.push_back('{t + 3*i + 1, a, 1'b0, 32'h0, 4'h0});
      resp_q.push_back('{t + 3*i + 2, 1'(i % 2), 1'b1, rd_fn(a)});
    end
    @(negedge clock);
    chk("first_if_ready", 64'(if_req_ready), 64'd1);
    chk("first_ls_ready", 64'(ls_req_ready), 64'd0);
    repeat (12) tick();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;

    // Single IFU read.
    t = cyc;
    if_req_valid = 1'b1; if_addr = 32'h8000_0000;
    mem_q.push_back('{t + 1, 32'h8000_0000, 1'b0, 32'h0, 4'h0});
    resp_q.push_back('{t + 2, 1'b0, 1'b1, 32'h0000_0413});
    tick();
    if_req_valid = 1'b0;
    tick();
    tick();

    // LSU write: payload must reach memory bit-exact.
    t = cyc;
    ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_1000;
    ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'h3;
    mem_q.push_back('{t + 1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3});
    resp_q.push_back('{t + 2, 1'b1, 1'b0, 32'h0});
    tick();
    ls_req_valid = 1'b0; ls_wen = 1'b0;
    tick();
    tick();
    @(negedge clock);
    chk("if_data_held", 64'(if_resp_data), 64'h413);
    tick();

    // Reset during the ISSUE cycle of an LSU read: transaction disappears.
    ls_req_valid = 1'b1; ls_addr = 32'h8000_3000;
    tick();
    ls_req_valid = 1'b0;
    reset = 1'b1;
    if_req_valid = 1'b1; if_addr = 32'h8000_0008;
    @(negedge clock);
    chk("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("mid_rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("mid_rst_if_ready", 64'(if_req_ready), 64'd0);
    chk("mid_rst_ls_ready", 64'(ls_req_ready), 64'd0);
    chk("mid_rst_if_resp", 64'(if_resp_valid), 64'd0);
    chk("mid_rst_ls_resp", 64'(ls_resp_valid), 64'd0);
    tick();
    reset = 1'b0;
    t = cyc;
    mem_q.push_back('{t + 1, 32'h8000_0008, 1'b0, 32'h0, 4'h0});
    resp_q.push_back('{t + 2, 1'b0, 1'b1, rd_fn(32'h8000_0008)});
    @(negedge clock);
    chk("post_rst_if_ready", 64'(if_req_ready), 64'd1);
    chk("post_rst_if_data", 64'(if_resp_data), 64'd0);
    chk("post_rst_ls_data", 64'(ls_resp_data), 64'd0);
    tick();
    if_req_valid = 1'b0;
    tick();
    tick();

    // Back-to-back IFU reads; response data must hold between responses.
    hold[0] = rd_fn(32'h8000_0008);
    hold[1] = rd_fn(32'h8000_0000);
    hold[2] = rd_fn(32'h8000_0004);
    t = cyc;
    if_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h8000_0000 + 32'(4 * i);
      mem_q.push_back('{t + 3*i + 1, a, 1'b0, 32'h0, 4'h0});
      resp_q.push_back('{t + 3*i + 2, 1'b0, 1'b1, rd_fn(a)});
    end
    for (int j = 0; j < 9; j++) begin
      if (j % 3 == 0) if_addr = 32'h8000_0000 + 32'(4 * (j / 3));
      @(negedge clock);
      if (j % 3 != 2) chk("if_data_stable", 64'(if_resp_data), 64'(hold[j / 3]));
      tick();
    end
    if_req_valid = 1'b0;
    repeat (3) tick();

    chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
